// File: rtl/parity_check_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_check_scheduler_pkg
// Description : Shared types and helpers for the parity check scheduler.
//               Provides the state encodings and the tag/counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_check_scheduler_pkg;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        SCH_IDLE   = 2'd0,
        SCH_SHIFT  = 2'd1,
        SCH_REPORT = 2'd2
    } sched_state_e;

    // Serial parity core state; Even must encode as 0
    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_state_e;

    // ceil(log2(n)) with a floor of one bit
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_check_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : parity_check_scheduler_if
// Description : Request and result handshake bundle between the requesters /
//               result consumer (master) and the scheduler (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface parity_check_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 8
);
    localparam int ID_W = parity_check_scheduler_pkg::id_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*WORD_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      res_valid;
    logic                      res_ready;
    logic [ID_W-1:0]           res_id;
    logic                      res_even;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_even
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_even
    );
endinterface
`default_nettype wire

// File: rtl/parity_check_scheduler_core.sv
`default_nettype none
// ============================================================================
// Module      : parity_serial_core
// Description : Two-state serial parity FSM. Toggles on each fed 1 bit; clr
//               restarts at Even and takes priority over bit_en.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_serial_core
    import parity_check_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    output logic even
);

    par_state_e state_q;
    par_state_e state_d;

    // Next parity state: restart on clr, otherwise toggle on a fed one
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = PAR_EVEN;
        end else if (bit_en && bit_in) begin
            state_d = (state_q == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
        end
    end

    // Parity state register, async active-low reset to Even
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PAR_EVEN;
        end else begin
            state_q <= state_d;
        end
    end

    assign even = (state_q == PAR_EVEN);

endmodule
`default_nettype wire

// File: rtl/parity_check_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : parity_check_scheduler
// Description : Round-robin shares one serial parity core among NUM_REQ
//               requesters; shifts the granted word LSB-first and returns the
//               parity result tagged with the requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_check_scheduler
    import parity_check_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    parity_check_scheduler_if.slave  bus
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = id_width(WORD_W);

    localparam logic [1:0] ST_IDLE   = SCH_IDLE;
    localparam logic [1:0] ST_SHIFT  = SCH_SHIFT;
    localparam logic [1:0] ST_REPORT = SCH_REPORT;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic              res_valid_q, res_valid_d;

    logic [ID_W-1:0]   grant;
    logic              accept;
    logic              clr;
    logic              bit_en;
    logic              core_even;

    // First valid index scanning upward from last+1, wrapping; last itself
    // is visited last so it only wins when it is the sole requester.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] g;
        int              idx;
        g = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (v[idx]) begin
                g = ID_W'(idx);
            end
        end
        return g;
    endfunction

    // Grant selection and one-hot ready, only offered while idle
    always_comb begin
        grant         = rr_pick(bus.req_valid, last_q);
        accept        = (state_q == ST_IDLE) && (|bus.req_valid);
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    // Scheduler sequencing: load, shift WORD_W bits, report until consumed
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        last_d      = last_q;
        res_valid_d = res_valid_q;
        clr         = 1'b0;
        bit_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = bus.req_data[int'(grant) * WORD_W +: WORD_W];
                    grant_d = grant;
                    cnt_d   = '0;
                    clr     = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_en  = 1'b1;
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    res_valid_d = 1'b1;
                    state_d     = ST_REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REPORT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    last_d      = grant_q;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scheduler registers; reset gives requester 0 first priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            last_q      <= ID_W'(NUM_REQ - 1);
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            res_valid_q <= res_valid_d;
        end
    end

    parity_serial_core u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .bit_en (bit_en),
        .bit_in (shift_q[0]),
        .even   (core_even)
    );

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = grant_q;
    assign bus.res_even  = core_even;

endmodule
`default_nettype wire

// File: tb/tb_parity_check_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_check_scheduler
// Description : Scoreboard bench for the parity check scheduler: a 4x8
//               instance under directed and random traffic, plus a 1x2
//               instance streaming back-to-back words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_check_scheduler;

    localparam int NR  = 4;
    localparam int WW  = 8;
    localparam int IDW = 2;

    typedef struct {
        int id;
        bit even;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    exp_t exp_q[$];
    exp_t exp1_q[$];

    // reference model state: 0 idle, 1 shifting, 2 reporting
    int m_state = 0;
    int m_left  = 0;
    int m_id    = 0;
    int m_last  = NR - 1;

    always #5 clk = ~clk;

    parity_check_scheduler_if #(.NUM_REQ(NR), .WORD_W(WW)) bus  ();
    parity_check_scheduler_if #(.NUM_REQ(1),  .WORD_W(2))  bus1 ();

    parity_check_scheduler #(.NUM_REQ(NR), .WORD_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    parity_check_scheduler #(.NUM_REQ(1), .WORD_W(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit ref_even(input logic [63:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic int ref_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // reference model: predicts grants, timing and results of the 4x8 DUT
    initial begin
        logic [NR-1:0] er;
        int p;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                m_state = 0;
                m_last  = NR - 1;
                chk("rst_req_ready", bus.req_ready, 0);
                chk("rst_res_valid", bus.res_valid, 0);
                chk("rst_res_id",    bus.res_id,    0);
                chk("rst_res_even",  bus.res_even,  1);
            end else begin
                case (m_state)
                    0: begin
                        p  = ref_pick(bus.req_valid, m_last);
                        er = '0;
                        if (p >= 0) er[p] = 1'b1;
                        chk("req_ready_grant", bus.req_ready, er);
                        chk("res_valid_idle",  bus.res_valid, 0);
                        if (p >= 0) begin
                            exp_q.push_back('{p, ref_even(64'(bus.req_data[p*WW +: WW])), cyc});
                            m_id    = p;
                            m_left  = WW;
                            m_state = 1;
                        end
                    end
                    1: begin
                        chk("req_ready_shift", bus.req_ready, 0);
                        chk("res_valid_shift", bus.res_valid, 0);
                        m_left--;
                        if (m_left == 0) m_state = 2;
                    end
                    default: begin
                        chk("req_ready_report", bus.req_ready, 0);
                        chk("res_valid_report", bus.res_valid, 1);
                        if (bus.res_ready) begin
                            m_last  = m_id;
                            m_state = 0;
                        end
                    end
                endcase
            end
        end
    end

    // result monitor for the 4x8 DUT: pops expectations, checks hold stability
    initial begin
        bit              held;
        logic [IDW-1:0]  hid;
        logic            he;
        exp_t            e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_res_valid", bus.res_valid, 1);
                    chk("hold_res_id",    bus.res_id,    hid);
                    chk("hold_res_even",  bus.res_even,  he);
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_result: got res_id %0d, expected no result", bus.res_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_id",   bus.res_id,   e.id);
                        chk("res_even", bus.res_even, e.even);
                    end
                end
                held = bus.res_valid && !bus.res_ready;
                hid  = bus.res_id;
                he   = bus.res_even;
            end
        end
    end

    // model and monitor for the 1x2 DUT: latency, period and result
    initial begin
        exp_t e;
        int   last1 = -1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp1_q.delete();
                last1 = -1;
            end else begin
                if (bus1.req_valid[0] && bus1.req_ready[0])
                    exp1_q.push_back('{0, ref_even(64'(bus1.req_data)), cyc});
                if (bus1.res_valid && bus1.res_ready) begin
                    if (exp1_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_result1: got res_id %0d, expected no result", bus1.res_id);
                    end else begin
                        e = exp1_q.pop_front();
                        chk("res_id1",   bus1.res_id,   e.id);
                        chk("res_even1", bus1.res_even, e.even);
                        chk("latency1",  cyc - e.cyc,   3);
                        if (last1 >= 0) chk("period1", cyc - last1, 4);
                        last1 = cyc;
                    end
                end
            end
        end
    end

    task automatic send(input int id, input logic [WW-1:0] d);
        int n = 0;
        bus.req_valid[id]           = 1'b1;
        bus.req_data[id*WW +: WW]   = d;
        while (n < 200) begin
            @(negedge clk);
            if (bus.req_ready[id]) break;
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: requester %0d not granted, expected grant within 200 cycles", id);
        end
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_state != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200us");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] g;
        logic [1:0]    seq1 [8];
        int            idx;
        int            n;

        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.res_ready  = 1'b1;
        bus1.req_valid = '0;
        bus1.req_data  = '0;
        bus1.res_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // idle with no requests
        repeat (20) begin
            @(negedge clk);
            chk("idle_req_ready", bus.req_ready, 0);
            chk("idle_res_valid", bus.res_valid, 0);
            chk("idle_res_id",    bus.res_id,    0);
            chk("idle_res_even",  bus.res_even,  1);
        end
        @(posedge clk);
        #1;

        // single requester, directed words
        send(2, 8'h01); drain();
        send(2, 8'hFF); drain();
        send(2, 8'h00); drain();

        // all four continuously valid from a fresh reset
        reset_pulse();
        for (int i = 0; i < NR; i++) bus.req_data[i*WW +: WW] = WW'($urandom);
        bus.req_valid = '1;
        repeat (50) begin
            @(negedge clk);
            g = bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++)
                if (g[i]) bus.req_data[i*WW +: WW] = WW'($urandom);
        end
        bus.req_valid = '0;
        drain();

        // back-pressure: hold REPORT for 5 cycles with competing requests
        bus.res_ready = 1'b0;
        bus.req_data  = {NR{8'h5A}};
        bus.req_valid = 4'b0011;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid_seen", bus.res_valid, 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        bus.req_valid = '0;
        drain();

        // reset in the middle of shifting requester 1's word
        bus.req_valid[1]       = 1'b1;
        bus.req_data[1*WW +: WW] = 8'h07;
        n = 0;
        while (!bus.req_ready[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_pulse();
        bus.req_valid[1]         = 1'b1;
        bus.req_data[1*WW +: WW] = 8'hC4;
        send(0, 8'h03);
        repeat (12) @(posedge clk);
        #1;
        bus.req_valid = '0;
        drain();

        // random traffic with random back-pressure
        repeat (400) begin
            @(posedge clk);
            #1;
            bus.res_ready = ($urandom_range(3) != 0);
            bus.req_valid = NR'($urandom);
            bus.req_data  = {$urandom, $urandom};
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        drain();

        // 1x2 instance, back-to-back words
        seq1[0] = 2'b10;
        for (int i = 1; i < 8; i++) seq1[i] = 2'($urandom);
        idx = 0;
        bus1.req_data  = seq1[0];
        bus1.req_valid = 1'b1;
        n = 0;
        while (idx < 8 && n < 100) begin
            @(negedge clk);
            g[0] = bus1.req_ready[0];
            @(posedge clk);
            #1;
            if (g[0]) begin
                idx++;
                if (idx < 8) bus1.req_data = seq1[idx];
            end
            n++;
        end
        bus1.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        chk("exp_q_empty",  exp_q.size(),  0);
        chk("exp1_q_empty", exp1_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parity_check_scheduler.md
# parity_check_scheduler

Shares one serial even/odd parity checker among NUM_REQ requesters, each offering a parallel WORD_W-bit word over a valid/ready handshake. A round-robin arbiter grants one requester, the word is shifted LSB-first through the serial checker one bit per cycle, and the result is returned tagged with the requester index. The block sits between the parallel request sources and the serial parity FSM datapath, and sequences that datapath's restart, bit-feed and result capture.

## Interface
- NUM_REQ, 4, number of requesters (1..16)
- WORD_W, 8, bits per word (2..64)
- ID_W, derived = max(1, ceil(log2(NUM_REQ))), width of the result tag
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W]
- req_ready  out  NUM_REQ  one-hot accept; transfer on req_valid[i] & req_ready[i]
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_id  out  ID_W  index of the requester whose word was checked
- res_even  out  1  1 = even number of ones in the word, 0 = odd

## Operation
- Scheduler FSM states: IDLE, SHIFT, REPORT. Reset state IDLE.
- IDLE: if any req_valid, pick g = first valid index scanning upward from (last+1) mod NUM_REQ, wrapping. req_ready[g]=1 combinationally this cycle, all other bits 0. On transfer: load shift register with req_data[g], latch g, pulse clear to the parity core (state → Even), bit counter := 0, go to SHIFT.
- No req_valid in IDLE: req_ready all 0, stay IDLE.
- SHIFT: each cycle feed shift_reg[0] to the core with bit_en=1, shift right, counter+1. When counter == WORD_W-1 (last bit fed), go to REPORT; the core's registered output is valid on entering REPORT.
- REPORT: res_valid=1, res_id=latched g, res_even=core output; all held stable until res_ready. On res_valid & res_ready: last := g, go IDLE.
- req_ready is 0 in SHIFT and REPORT. Requesters may drop req_valid while not granted; no grant is then issued to them.
- Counter width ceil(log2(WORD_W)); never exceeds WORD_W-1.
- rst assertion at any point (mid-SHIFT, mid-REPORT) aborts: in-flight word discarded, no result emitted, all registers to reset values.

## Timing
- Reset values: req_ready 0 (asserted rst forces IDLE and masks it), res_valid 0, res_id 0, res_even 1, last = NUM_REQ-1 (requester 0 has first priority), core state Even.
- Accept at edge T → SHIFT for cycles T+1..T+WORD_W → res_valid high from T+WORD_W+1.
- res_ready held high: result accepted the first REPORT cycle; next accept earliest one cycle later in IDLE. Minimum period per word WORD_W+2 cycles.
- res_ready low: REPORT holds indefinitely; no new grant meanwhile.
- All outputs except req_ready are registered; req_ready depends combinationally on req_valid and FSM state only.

## Structure
- Shared package: scheduler state enum {IDLE, SHIFT, REPORT}; parity state enum {Even, Odd} (Even encoded 0); ID_W derivation function.
- Sub-module parity_serial_core: clk, rst, clr, bit_en, bit_in, even out; two-state Even/Odd FSM, toggles on bit_en & bit_in, clr forces Even (clr wins over bit_en), even = (state == Even), reset Even.
- Round-robin pick is a function in the scheduler, not a separate module.

## Test plan
- Reset, no requests: req_ready 0, res_valid 0, res_even 1, res_id 0 held for 20 cycles.
- Single request, NUM_REQ=4, WORD_W=8: requester 2 data 0x01 → accepted at T, res_valid at T+9 with res_id 2, res_even 0; data 0xFF → res_even 1; data 0x00 → res_even 1.
- All four valid continuously, res_ready=1: grants in order 0,1,2,3,0; results spaced 10 cycles; each res_id matches grant order.
- Back-pressure: res_ready=0 for 5 cycles in REPORT → res_valid/res_id/res_even stable, req_ready stays 0; accept on cycle 6, grant resumes next cycle.
- Reset mid-SHIFT (after 3 bits of 0x07 from requester 1): no result emitted; after release, requester 0 granted first and 0x03 yields res_even 1 (core restarted from Even).
- NUM_REQ=1, WORD_W=2: data 2'b10 → res_id 0, res_even 0 at T+3; back-to-back words every 4 cycles.
